// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display arbiter and other display producers:
// arbiter state encoding, segment constants and the hex-to-glyph decoder.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } seg_arb_state_t;

    // Segment bit order is {g,f,e,d,c,b,a}, active high.
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b0111111;
            4'h1:    seg = 7'b0000110;
            4'h2:    seg = 7'b1011011;
            4'h3:    seg = 7'b1001111;
            4'h4:    seg = 7'b1100110;
            4'h5:    seg = 7'b1101101;
            4'h6:    seg = 7'b1111101;
            4'h7:    seg = 7'b0000111;
            4'h8:    seg = 7'b1111111;
            4'h9:    seg = 7'b1101111;
            4'hA:    seg = 7'b1110111;
            4'hB:    seg = 7'b1111100;
            4'hC:    seg = 7'b0111001;
            4'hD:    seg = 7'b1011110;
            4'hE:    seg = 7'b1111001;
            4'hF:    seg = 7'b1110001;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_display_arbiter_rr_select.sv
// Combinational round-robin picker: first asserted valid bit at or after ptr, wrapping.
module rr_select #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [1:0]       ptr,
    output logic             any,
    output logic [1:0]       sel
);

    // Scan offsets 0..N_REQ-1 from the pointer; the first hit wins.
    always_comb begin
        any = 1'b0;
        sel = 2'd0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any && valid[(int'(ptr) + i) % N_REQ]) begin
                any = 1'b1;
                sel = 2'((int'(ptr) + i) % N_REQ);
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing a 4-digit seven-segment display between N_REQ requesters.
// Optional SEG_ARB_BLANK_EN: return the display to dashes when a hold expires with no request pending.
module seg_display_arbiter
    import seg_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int HOLD_CYCLES = 100_000_000,
    parameter int CNT_W       = 27
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*16-1:0]   req_data,
    output logic [N_REQ-1:0]      req_ready,
    output logic [6:0]            digit0_segments,
    output logic [6:0]            digit1_segments,
    output logic [6:0]            digit2_segments,
    output logic [6:0]            digit3_segments,
    output logic [1:0]            owner,
    output logic                  busy
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    seg_arb_state_t    state_r, state_s;
    logic [1:0]        owner_r, owner_s;
    logic [1:0]        rr_ptr_r, rr_ptr_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [N_REQ-1:0]  ready_r, ready_s;
    logic              busy_r, busy_s;
    logic              accept_s, blank_s;
    logic              owner_valid_s;
    logic [15:0]       owner_data_s;
    logic              pick_any_s;
    logic [1:0]        pick_sel_s;

    rr_select #(.N_REQ(N_REQ)) u_rr_select (
        .valid (req_valid),
        .ptr   (rr_ptr_r),
        .any   (pick_any_s),
        .sel   (pick_sel_s)
    );

    // Route the current owner's valid and data word.
    always_comb begin
        owner_valid_s = 1'b0;
        owner_data_s  = 16'h0000;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_r == 2'(i)) begin
                owner_valid_s = req_valid[i];
                owner_data_s  = req_data[i*16 +: 16];
            end else begin
                owner_valid_s = owner_valid_s;
            end
        end
    end

    // Next-state logic; an owner accept at counter zero takes priority over expiry.
    always_comb begin
        state_s  = state_r;
        owner_s  = owner_r;
        rr_ptr_s = rr_ptr_r;
        cnt_s    = cnt_r;
        accept_s = 1'b0;
        blank_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    state_s = GRANT;
                    owner_s = pick_sel_s;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: begin
                if (owner_valid_s) begin
                    accept_s = 1'b1;
                    cnt_s    = HOLD_LOAD;
                    state_s  = HOLD;
                end else begin
                    state_s  = IDLE;
                end
            end
            HOLD: begin
                if (owner_valid_s) begin
                    accept_s = 1'b1;
                    cnt_s    = HOLD_LOAD;
                end else if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s  = IDLE;
                    rr_ptr_s = (owner_r == 2'(N_REQ - 1)) ? 2'd0 : owner_r + 2'd1;
`ifdef SEG_ARB_BLANK_EN
                    blank_s  = (req_valid == {N_REQ{1'b0}});
`else
                    blank_s  = 1'b0;
`endif
                end else begin
                    cnt_s    = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Ready and busy are decoded from the next state so they come out of flops.
    always_comb begin
        ready_s = {N_REQ{1'b0}};
        busy_s  = (state_s != IDLE);
        for (int i = 0; i < N_REQ; i++) begin
            if ((state_s != IDLE) && (owner_s == 2'(i))) begin
                ready_s[i] = 1'b1;
            end else begin
                ready_s[i] = 1'b0;
            end
        end
    end

    // Arbiter state, owner, pointer and hold counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            owner_r  <= 2'd0;
            rr_ptr_r <= 2'd0;
            cnt_r    <= {CNT_W{1'b0}};
            ready_r  <= {N_REQ{1'b0}};
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            owner_r  <= owner_s;
            rr_ptr_r <= rr_ptr_s;
            cnt_r    <= cnt_s;
            ready_r  <= ready_s;
            busy_r   <= busy_s;
        end
    end

    // Display registers: decode on accept, dash on reset or blanking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit0_segments <= SEG_DASH;
            digit1_segments <= SEG_DASH;
            digit2_segments <= SEG_DASH;
            digit3_segments <= SEG_DASH;
        end else if (accept_s) begin
            digit0_segments <= hex_to_seg(owner_data_s[3:0]);
            digit1_segments <= hex_to_seg(owner_data_s[7:4]);
            digit2_segments <= hex_to_seg(owner_data_s[11:8]);
            digit3_segments <= hex_to_seg(owner_data_s[15:12]);
        end else if (blank_s) begin
            digit0_segments <= SEG_DASH;
            digit1_segments <= SEG_DASH;
            digit2_segments <= SEG_DASH;
            digit3_segments <= SEG_DASH;
        end else begin
            digit0_segments <= digit0_segments;
            digit1_segments <= digit1_segments;
            digit2_segments <= digit2_segments;
            digit3_segments <= digit3_segments;
        end
    end

    assign req_ready = ready_r;
    assign busy      = busy_r;
    assign owner     = owner_r;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed, table-driven bench for seg_display_arbiter with N_REQ=2 and HOLD_CYCLES=8.
module tb_seg_display_arbiter;

    localparam logic [27:0] DASH4 = {4{7'b1000000}};
    localparam logic [27:0] G12AF = {7'b0000110, 7'b1011011, 7'b1110111, 7'b1110001};
    localparam logic [27:0] G6080 = {7'b1111101, 7'b0111111, 7'b1111111, 7'b0111111};
    localparam logic [27:0] G0003 = {7'b0111111, 7'b0111111, 7'b0111111, 7'b1001111};
    localparam logic [27:0] G4B5E = {7'b1100110, 7'b1111100, 7'b1101101, 7'b1111001};
    localparam logic [27:0] G79CD = {7'b0000111, 7'b1101111, 7'b0111001, 7'b1011110};
    localparam logic [27:0] GBEEF = {7'b1111100, 7'b1111001, 7'b1111001, 7'b1110001};
`ifdef SEG_ARB_BLANK_EN
    localparam logic [27:0] POST1 = DASH4;
    localparam logic [27:0] POST2 = DASH4;
    localparam logic [27:0] POST3 = DASH4;
`else
    localparam logic [27:0] POST1 = G12AF;
    localparam logic [27:0] POST2 = G4B5E;
    localparam logic [27:0] POST3 = GBEEF;
`endif

    typedef struct {
        logic        rst_n;
        logic [1:0]  valid;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [1:0]  ready;
        logic        busy;
        logic [1:0]  owner;
        logic [27:0] segs;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [31:0] req_data;
    logic [1:0]  req_ready;
    logic [6:0]  digit0_segments, digit1_segments, digit2_segments, digit3_segments;
    logic [1:0]  owner;
    logic        busy;
    logic [27:0] segs;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    assign segs = {digit3_segments, digit2_segments, digit1_segments, digit0_segments};

    seg_display_arbiter #(.N_REQ(2), .HOLD_CYCLES(8), .CNT_W(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .digit0_segments (digit0_segments),
        .digit1_segments (digit1_segments),
        .digit2_segments (digit2_segments),
        .digit3_segments (digit3_segments),
        .owner           (owner),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic r, input logic [1:0] v, input logic [15:0] d0, input logic [15:0] d1,
                        input logic [1:0] er, input logic eb, input logic [1:0] eo, input logic [27:0] es);
        vec_t x;
        x.rst_n = r; x.valid = v; x.d0 = d0; x.d1 = d1;
        x.ready = er; x.busy = eb; x.owner = eo; x.segs = es;
        vecs.push_back(x);
    endtask

    initial begin
        int cyc;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_data  = 32'h0000_0000;

        // Single request from reset, then hold expiry.
        push(1'b1, 2'b01, 16'h12AF, 16'h0000, 2'b00, 1'b0, 2'd0, DASH4);
        push(1'b1, 2'b01, 16'h12AF, 16'h0000, 2'b01, 1'b1, 2'd0, DASH4);
        for (int i = 0; i < 8; i++) push(1'b1, 2'b00, 16'h12AF, 16'h0000, 2'b01, 1'b1, 2'd0, G12AF);
        // Requester 1 granted then withdraws.
        push(1'b1, 2'b10, 16'h12AF, 16'h4B5E, 2'b00, 1'b0, 2'd0, POST1);
        push(1'b1, 2'b00, 16'h12AF, 16'h4B5E, 2'b10, 1'b1, 2'd1, POST1);
        push(1'b1, 2'b00, 16'h12AF, 16'h4B5E, 2'b00, 1'b0, 2'd1, POST1);
        push(1'b0, 2'b00, 16'h12AF, 16'h4B5E, 2'b00, 1'b0, 2'd1, POST1);
        // Simultaneous requests from reset, owner refresh at counter zero.
        push(1'b1, 2'b11, 16'h6080, 16'h4B5E, 2'b00, 1'b0, 2'd0, DASH4);
        push(1'b1, 2'b11, 16'h6080, 16'h4B5E, 2'b01, 1'b1, 2'd0, DASH4);
        for (int i = 0; i < 7; i++) push(1'b1, 2'b10, 16'h6080, 16'h4B5E, 2'b01, 1'b1, 2'd0, G6080);
        push(1'b1, 2'b11, 16'h0003, 16'h4B5E, 2'b01, 1'b1, 2'd0, G6080);
        for (int i = 0; i < 8; i++) push(1'b1, 2'b10, 16'h0003, 16'h4B5E, 2'b01, 1'b1, 2'd0, G0003);
        push(1'b1, 2'b10, 16'h0003, 16'h4B5E, 2'b00, 1'b0, 2'd0, G0003);
        push(1'b1, 2'b10, 16'h0003, 16'h4B5E, 2'b10, 1'b1, 2'd1, G0003);
        for (int i = 0; i < 8; i++) push(1'b1, 2'b00, 16'h0003, 16'h4B5E, 2'b10, 1'b1, 2'd1, G4B5E);
        // Pointer wraps back to requester 0.
        push(1'b1, 2'b11, 16'h0003, 16'h4B5E, 2'b00, 1'b0, 2'd1, POST2);
        push(1'b1, 2'b00, 16'h0003, 16'h4B5E, 2'b01, 1'b1, 2'd0, POST2);
        push(1'b1, 2'b00, 16'h0003, 16'h4B5E, 2'b00, 1'b0, 2'd0, POST2);

        repeat (3) @(negedge clk);
        foreach (vecs[k]) begin
            @(negedge clk);
            chk($sformatf("ready[%0d]", k), 32'(req_ready), 32'(vecs[k].ready));
            chk($sformatf("busy[%0d]", k), 32'(busy), 32'(vecs[k].busy));
            chk($sformatf("owner[%0d]", k), 32'(owner), 32'(vecs[k].owner));
            chk($sformatf("segs[%0d]", k), 32'(segs), 32'(vecs[k].segs));
            rst_n     = vecs[k].rst_n;
            req_valid = vecs[k].valid;
            req_data  = {vecs[k].d1, vecs[k].d0};
        end

        // Asynchronous reset in the middle of a hold.
        @(negedge clk);
        req_valid = 2'b10;
        req_data  = {16'h79CD, 16'h0000};
        @(negedge clk);
        chk("mid_grant_ready", 32'(req_ready), 32'h2);
        @(negedge clk);
        chk("mid_hold_segs", 32'(segs), 32'(G79CD));
        req_valid = 2'b00;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_segs", 32'(segs), 32'(DASH4));
        chk("async_rst_busy", 32'(busy), 32'h0);
        chk("async_rst_ready", 32'(req_ready), 32'h0);
        chk("async_rst_owner", 32'(owner), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Hold length and post-expiry display with no pending request.
        @(negedge clk);
        req_valid = 2'b01;
        req_data  = {16'h0000, 16'hBEEF};
        @(negedge clk);
        chk("blank_grant_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        chk("blank_hold_segs", 32'(segs), 32'(GBEEF));
        req_valid = 2'b00;
        cyc = 0;
        while (busy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("hold_busy_timeout", 32'(busy), 32'h0);
        chk("hold_length", 32'(cyc), 32'd8);
        chk("post_expiry_segs", 32'(segs), 32'(POST3));
        @(negedge clk);
        chk("idle_segs_stable", 32'(segs), 32'(POST3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
